// File: rtl/ahb_register_file_if.sv
// AHB-Lite slave-side bus bundle for ahb_register_file.
// The decoder/interconnect drives the master side.
interface ahb_register_file_if;
  logic        h_sel;
  logic [1:0]  h_trans;
  logic        h_ready;
  logic [31:0] h_addr;
  logic        h_write;
  logic [2:0]  h_size;
  logic [3:0]  h_wstrb;
  logic [31:0] h_wdata;
  logic [31:0] h_rdata;
  logic        h_readyout;
  logic        h_resp;

  modport master (
    output h_sel, h_trans, h_ready, h_addr, h_write, h_size, h_wstrb, h_wdata,
    input  h_rdata, h_readyout, h_resp
  );

  modport slave (
    input  h_sel, h_trans, h_ready, h_addr, h_write, h_size, h_wstrb, h_wdata,
    output h_rdata, h_readyout, h_resp
  );
endinterface

// File: rtl/ahb_register_file.sv
// AHB-Lite register slave: NumRegs x 32-bit registers, read-only hardware status slots,
// byte-lane write strobes, programmable read/write wait states and a two-cycle ERROR response.
module ahb_register_file #(
  parameter logic [31:0]        BaseAddr        = 32'h3000_1000,
  parameter int                 NumRegs         = 64,
  parameter logic [NumRegs-1:0] ReadOnlyMask    = {NumRegs{1'b0}},
  parameter int                 ReadWaitStates  = 0,
  parameter int                 WriteWaitStates = 0
) (
  input  logic                    h_clk,
  input  logic                    h_reset_n,
  ahb_register_file_if.slave      bus,
  input  logic [32*NumRegs-1:0]   hw_in,
  output logic [32*NumRegs-1:0]   reg_out
);
  localparam int          IdxW      = $clog2(NumRegs);
  localparam logic [31:0] SpanBytes = 32'(4 * NumRegs);
  localparam logic [2:0]  RdWait    = 3'(ReadWaitStates);
  localparam logic [2:0]  WrWait    = 3'(WriteWaitStates);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            vld_p1, vld_d;
  logic            write_p1;
  logic [2:0]      size_p1;
  logic [1:0]      lane_p1;
  logic [IdxW-1:0] idx_p1;
  logic [31:0]     regs [NumRegs];

  logic [31:0]     offset_p0;
  logic [IdxW-1:0] idx_p0;
  logic            err_p0;
  logic            slot_open;
  logic            accept_p0;
  logic [2:0]      wait_p0;
  logic            final_ok;
  logic [3:0]      byte_en;
  logic [31:0]     rd_word;
  logic            unused_trans;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000:  lane_mask = 4'b0001 << a;
      3'b001:  lane_mask = a[1] ? 4'b1100 : 4'b0011;
      3'b010:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Address phase: decode and classify the incoming transfer
  assign offset_p0 = bus.h_addr - BaseAddr;
  assign idx_p0    = offset_p0[IdxW+1:2];
  assign err_p0    = (offset_p0 >= SpanBytes)
                   | (bus.h_size > 3'b010)
                   | ((bus.h_size == 3'b001) & bus.h_addr[0])
                   | ((bus.h_size == 3'b010) & (bus.h_addr[1:0] != 2'b00))
                   | (bus.h_write & ReadOnlyMask[idx_p0]);
  assign slot_open = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
  assign accept_p0 = bus.h_sel & bus.h_trans[1] & bus.h_ready & slot_open;
  assign wait_p0   = bus.h_write ? WrWait : RdWait;
  assign unused_trans = bus.h_trans[0];

  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_p1  <= vld_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    vld_d          = vld_p1;
    bus.h_readyout = 1'b1;
    bus.h_resp     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        bus.h_readyout = 1'b0;
        if (cnt_q <= 3'd1) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: begin
        bus.h_readyout = 1'b0;
        bus.h_resp     = 1'b1;
        state_d        = ST_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all finish a data phase and may take the next address
        bus.h_resp = (state_q == ST_ERR2);
        state_d    = ST_IDLE;
        vld_d      = 1'b0;
        if (accept_p0) begin
          if (err_p0) begin
            state_d = ST_ERR1;
          end else begin
            vld_d = 1'b1;
            if (wait_p0 != 3'd0) begin
              state_d = ST_WAIT;
              cnt_d   = wait_p0;
            end
          end
        end
      end
    endcase
  end

  // Data phase: address-phase attributes held for the transfer in flight
  always_ff @(posedge h_clk) begin
    if (accept_p0) begin
      write_p1 <= bus.h_write;
      size_p1  <= bus.h_size;
      lane_p1  <= bus.h_addr[1:0];
      idx_p1   <= idx_p0;
    end
  end

  assign final_ok = vld_p1 & ((state_q == ST_IDLE) | (state_q == ST_DATA));
  assign byte_en  = lane_mask(size_p1, lane_p1) & bus.h_wstrb;

  always_ff @(posedge h_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= 32'd0;
    end else if (final_ok && write_p1) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) regs[idx_p1][8*b +: 8] <= bus.h_wdata[8*b +: 8];
      end
    end
  end

  assign rd_word     = ReadOnlyMask[idx_p1] ? hw_in[{idx_p1, 5'd0} +: 32] : regs[idx_p1];
  assign bus.h_rdata = (final_ok && !write_p1) ? rd_word : 32'd0;

  for (genvar g = 0; g < NumRegs; g++) begin : g_out
    assign reg_out[32*g +: 32] = ReadOnlyMask[g] ? hw_in[32*g +: 32] : regs[g];
  end
endmodule

// File: tb/tb_ahb_register_file.sv
// Randomized bench for ahb_register_file: two instances (zero-wait and 2/1-wait with
// read-only slots 3 and 17) driven in turn and checked against a transaction-level model.
module tb_ahb_register_file;
  localparam logic [31:0] BASE = 32'h3000_1000;
  localparam int          NR   = 64;

  typedef struct {
    bit          idle;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } xfer_t;

  logic              h_clk = 1'b0;
  logic              h_reset_n = 1'b0;
  logic              mode = 1'b0;
  logic              d_sel = 1'b0;
  logic [1:0]        d_trans = 2'b00;
  logic [31:0]       d_addr = 32'd0;
  logic              d_write = 1'b0;
  logic [2:0]        d_size = 3'd0;
  logic [3:0]        d_wstrb = 4'd0;
  logic [31:0]       d_wdata = 32'd0;
  logic [32*NR-1:0]  hw_in = '0;
  logic [32*NR-1:0]  reg_out0, reg_out1;
  logic              obs_ready, obs_resp;
  logic [31:0]       obs_rdata;

  logic [31:0] mem [2][NR];
  xfer_t       q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 h_clk = ~h_clk;

  ahb_register_file_if bus0();
  ahb_register_file_if bus1();

  assign bus0.h_sel   = d_sel & ~mode;
  assign bus1.h_sel   = d_sel & mode;
  assign bus0.h_trans = d_trans;  assign bus1.h_trans = d_trans;
  assign bus0.h_addr  = d_addr;   assign bus1.h_addr  = d_addr;
  assign bus0.h_write = d_write;  assign bus1.h_write = d_write;
  assign bus0.h_size  = d_size;   assign bus1.h_size  = d_size;
  assign bus0.h_wstrb = d_wstrb;  assign bus1.h_wstrb = d_wstrb;
  assign bus0.h_wdata = d_wdata;  assign bus1.h_wdata = d_wdata;
  assign bus0.h_ready = bus0.h_readyout;
  assign bus1.h_ready = bus1.h_readyout;

  assign obs_ready = mode ? bus1.h_readyout : bus0.h_readyout;
  assign obs_resp  = mode ? bus1.h_resp     : bus0.h_resp;
  assign obs_rdata = mode ? bus1.h_rdata    : bus0.h_rdata;

  ahb_register_file #(
    .BaseAddr(BASE), .NumRegs(NR), .ReadOnlyMask({NR{1'b0}}),
    .ReadWaitStates(0), .WriteWaitStates(0)
  ) dut0 (
    .h_clk(h_clk), .h_reset_n(h_reset_n), .bus(bus0), .hw_in(hw_in), .reg_out(reg_out0)
  );

  ahb_register_file #(
    .BaseAddr(BASE), .NumRegs(NR), .ReadOnlyMask(64'h0000_0000_0002_0008),
    .ReadWaitStates(2), .WriteWaitStates(1)
  ) dut1 (
    .h_clk(h_clk), .h_reset_n(h_reset_n), .bus(bus1), .hw_in(hw_in), .reg_out(reg_out1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: rules applied per transfer, no cycle-level state
  function automatic bit is_ro(input int i);
    return mode && (i == 3 || i == 17);
  endfunction

  function automatic int wait_of(input bit wr);
    if (!mode) return 0;
    return wr ? 1 : 2;
  endfunction

  function automatic bit x_err(input xfer_t t);
    logic [31:0] off;
    off = t.addr - BASE;
    if (off >= 32'(4 * NR)) return 1'b1;
    if (t.size > 3'd2) return 1'b1;
    if ((t.addr & ((32'd1 << t.size) - 32'd1)) != 32'd0) return 1'b1;
    if (t.wr && is_ro(int'(off >> 2))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] x_read(input xfer_t t);
    int idx;
    if (t.idle || x_err(t)) return 32'd0;
    idx = int'((t.addr - BASE) >> 2);
    return is_ro(idx) ? hw_in[32*idx +: 32] : mem[int'(mode)][idx];
  endfunction

  task automatic x_write(input xfer_t t);
    int idx, first, nb;
    idx   = int'((t.addr - BASE) >> 2);
    first = int'(t.addr & 32'd3);
    nb    = 1 << t.size;
    for (int b = 0; b < 4; b++) begin
      if (b >= first && b < first + nb && t.strb[b])
        mem[int'(mode)][idx][8*b +: 8] = t.data[8*b +: 8];
    end
  endtask

  function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [3:0] strb, input logic [31:0] data);
    xfer_t t;
    t.idle = 1'b0; t.wr = wr; t.addr = addr; t.size = size; t.strb = strb; t.data = data;
    return t;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t t;
    int r, idx;
    r   = int'($urandom_range(0, 15));
    idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR-1));
    t.idle = (r == 0);
    t.wr   = 1'($urandom_range(0, 1));
    t.size = (r == 4) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    t.addr = BASE + 32'(idx * 4);
    if (t.size == 3'd0)      t.addr = t.addr + 32'($urandom_range(0, 3));
    else if (t.size == 3'd1) t.addr = t.addr + 32'(2 * $urandom_range(0, 1));
    if (r == 1) t.addr = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
    if (r == 2) t.addr = BASE + 32'(4 * NR) + 32'(4 * $urandom_range(0, 15));
    if (r == 3) t.addr = BASE - 32'd4;
    t.strb = 4'($urandom);
    t.data = $urandom;
    return t;
  endfunction

  task automatic drive_addr(input xfer_t t, input bit valid);
    d_sel   = valid;
    d_trans = (valid && !t.idle) ? 2'b10 : 2'b00;
    d_addr  = t.addr;
    d_write = t.wr;
    d_size  = t.size;
  endtask

  // Pipelined: the next address is presented during the current data phase
  task automatic run_burst();
    int n;
    n = q.size();
    if (n == 0) return;
    @(posedge h_clk); #1;
    drive_addr(q[0], 1'b1);
    for (int i = 0; i < n; i++) begin
      xfer_t t;
      bit e, done;
      int exp_cyc, cyc;
      logic [31:0] exp_rd;
      t       = q[i];
      e       = !t.idle && x_err(t);
      exp_cyc = t.idle ? 1 : (e ? 2 : wait_of(t.wr) + 1);
      exp_rd  = x_read(t);
      @(posedge h_clk); #1;
      d_wdata = t.data;
      d_wstrb = t.strb;
      if (i + 1 < n) drive_addr(q[i+1], 1'b1);
      else           drive_addr(t, 1'b0);
      cyc = 0; done = 1'b0;
      while (!done && cyc < 16) begin
        if (cyc > 0) begin @(posedge h_clk); #1; end
        @(negedge h_clk);
        cyc++;
        done = obs_ready;
        check($sformatf("resp m%0d x%0d c%0d", mode, i, cyc), 32'(obs_resp), 32'(e));
        if (!done || e || t.idle)
          check($sformatf("rdata_zero m%0d x%0d c%0d", mode, i, cyc), obs_rdata, 32'd0);
        else if (!t.wr)
          check($sformatf("rdata m%0d x%0d a=%h", mode, i, t.addr), obs_rdata, exp_rd);
      end
      check($sformatf("cycles m%0d x%0d a=%h", mode, i, t.addr), 32'(cyc), 32'(exp_cyc));
      if (!t.idle && !e && t.wr) x_write(t);
    end
    q.delete();
  endtask

  task automatic check_regout();
    @(posedge h_clk); #1;
    for (int i = 0; i < NR; i++) begin
      logic [31:0] got, exp;
      got = mode ? reg_out1[32*i +: 32] : reg_out0[32*i +: 32];
      exp = is_ro(i) ? hw_in[32*i +: 32] : mem[int'(mode)][i];
      check($sformatf("reg_out m%0d r%0d", mode, i), got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NR; i++) mem[m][i] = 32'd0;
    for (int k = 0; k < NR; k++) hw_in[32*k +: 32] = $urandom;

    // Reset state and zero-wait reads of every register
    #1;
    check("rst_readyout", 32'(obs_ready), 32'd1);
    check("rst_resp", 32'(obs_resp), 32'd0);
    check("rst_rdata", obs_rdata, 32'd0);
    #20 h_reset_n = 1'b1;
    for (int i = 0; i < NR; i++) q.push_back(mk(1'b0, BASE + 32'(4 * i), 3'd2, 4'h0, 32'd0));
    run_burst();

    // Byte strobes and sizes
    q.push_back(mk(1'b1, BASE,          3'd2, 4'hF,    32'hFFFF_FFFF));
    q.push_back(mk(1'b1, BASE + 32'd2,  3'd0, 4'hF,    32'hA5A5_A5A5));
    q.push_back(mk(1'b1, BASE,          3'd2, 4'b0001, 32'h1234_5678));
    q.push_back(mk(1'b0, BASE,          3'd2, 4'h0,    32'd0));
    run_burst();
    check_regout();
    check("strobe_reg0", reg_out0[31:0], 32'hFFA5_FF78);

    // Error responses leave registers untouched
    q.push_back(mk(1'b0, BASE + 32'd1,        3'd2, 4'h0, 32'd0));
    q.push_back(mk(1'b0, BASE + 32'(4 * NR),  3'd2, 4'h0, 32'd0));
    q.push_back(mk(1'b0, BASE,                3'd3, 4'h0, 32'd0));
    q.push_back(mk(1'b1, BASE,                3'd3, 4'hF, 32'd0));
    q.push_back(mk(1'b1, BASE + 32'd2,        3'd2, 4'hF, 32'd0));
    run_burst();
    check_regout();
    check("err_reg0_kept", reg_out0[31:0], 32'hFFA5_FF78);

    // Wait states: write then read back with no stall
    mode = 1'b1;
    q.push_back(mk(1'b1, BASE + 32'd8, 3'd2, 4'hF, 32'hDEAD_BEEF));
    q.push_back(mk(1'b0, BASE + 32'd8, 3'd2, 4'h0, 32'd0));
    run_burst();
    check_regout();
    check("waits_reg2", reg_out1[95:64], 32'hDEAD_BEEF);

    // Read-only register
    hw_in[32*3 +: 32] = 32'hCAFE_0003;
    q.push_back(mk(1'b1, BASE + 32'd12, 3'd2, 4'hF, 32'h0000_0000));
    q.push_back(mk(1'b0, BASE + 32'd12, 3'd2, 4'h0, 32'd0));
    run_burst();
    check_regout();

    // Randomized traffic on both instances
    for (int m = 0; m < 2; m++) begin
      mode = 1'(m);
      for (int b = 0; b < 6; b++) begin
        for (int k = 0; k < NR; k++) hw_in[32*k +: 32] = $urandom;
        for (int j = 0; j < 12; j++) q.push_back(rand_xfer());
        run_burst();
        check_regout();
      end
    end

    // Reset during the wait cycle of a write
    mode = 1'b1;
    @(posedge h_clk); #1;
    d_sel = 1'b1; d_trans = 2'b10; d_addr = BASE + 32'd20; d_write = 1'b1; d_size = 3'd2;
    @(posedge h_clk); #1;
    d_wdata = 32'h5555_5555; d_wstrb = 4'hF; d_sel = 1'b0; d_trans = 2'b00;
    @(negedge h_clk);
    check("rstmid_wait_readyout", 32'(obs_ready), 32'd0);
    h_reset_n = 1'b0;
    #1;
    check("rstmid_readyout", 32'(obs_ready), 32'd1);
    check("rstmid_resp", 32'(obs_resp), 32'd0);
    check("rstmid_rdata", obs_rdata, 32'd0);
    @(negedge h_clk);
    h_reset_n = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NR; i++) mem[m][i] = 32'd0;
    q.push_back(mk(1'b0, BASE + 32'd20, 3'd2, 4'h0, 32'd0));
    run_burst();
    check_regout();
    check("rstmid_reg5", reg_out1[32*5 +: 32], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_register_file.md
Name: ahb_register_file

Overview:
- Parametrised successor to the fixed 64 x 32-bit AHB-Lite register slave.
- Adds a configurable register count and base address, per-register read-only masking with hardware-driven status inputs, and configurable read/write wait states.
- Keeps the two-cycle AHB ERROR response and byte-lane write strobes.
- Sits behind the AHB interconnect decoder; h_sel and h_ready come from the interconnect.

Parameters:
- BaseAddr, 32'h3000_1000, byte address of register 0; must be aligned to 4*NumRegs.
- NumRegs, 64, number of 32-bit registers; power of two, 2..256.
- ReadOnlyMask, {NumRegs{1'b0}}, bit i = 1 makes register i read-only; its value comes from hw_in.
- ReadWaitStates, 0, wait cycles inserted before read data is returned (0..7).
- WriteWaitStates, 0, wait cycles inserted before a write completes (0..7).

Ports:
- h_clk  in  1  AHB clock, all logic on rising edge
- h_reset_n  in  1  asynchronous active-low reset
- h_sel  in  1  slave select from decoder
- h_trans  in  2  transfer type; NONSEQ/SEQ when bit 1 = 1
- h_ready  in  1  bus ready; an address phase is accepted only when h_ready = 1
- h_addr  in  32  byte address
- h_write  in  1  1 = write, 0 = read
- h_size  in  3  transfer size: 000 byte, 001 halfword, 010 word, others illegal
- h_wstrb  in  4  write strobes, sampled in the data phase
- h_wdata  in  32  write data, sampled in the data phase
- h_rdata  out  32  read data
- h_readyout  out  1  slave ready
- h_resp  out  1  0 = OKAY, 1 = ERROR
- hw_in  in  32*NumRegs  hardware values returned for read-only registers
- reg_out  out  32*NumRegs  current contents of all registers

Behaviour:
- Reset (async, h_reset_n = 0): all writable registers = 0; FSM = IDLE; h_readyout = 1; h_resp = 0; h_rdata = 0. Reset asserted mid-transfer aborts the transfer, and the register is not written.
- Accept condition: h_sel & h_trans[1] & h_ready at a rising edge. On accept, register h_addr, h_write, h_size and the error flag. IDLE/BUSY transfers or h_sel = 0 give a zero-wait OKAY.
- Error flag is set by any of:
  - offset = h_addr - BaseAddr is outside [0, 4*NumRegs);
  - h_size > 010;
  - misaligned access: halfword with addr[0] = 1, or word with addr[1:0] != 0;
  - write to a read-only register.
- FSM states:
  - IDLE: h_readyout = 1. On an accepted error transfer go to ERR1. On an accepted good transfer with wait count N > 0 go to WAIT with counter = N. With N = 0, stay in IDLE and complete in one data cycle.
  - WAIT: h_readyout = 0, h_resp = 0; counter decrements each cycle. When the counter reaches 1, go to DATA.
  - DATA: h_readyout = 1 for one cycle; the transfer completes. Return to IDLE, or accept the next pipelined address in that cycle.
  - ERR1: h_readyout = 0, h_resp = 1, for one cycle; then go to ERR2.
  - ERR2: h_readyout = 1, h_resp = 1; the transfer completes. Back-to-back accept is permitted here.
- Write commit:
  - The register is updated in the final data-phase cycle (the cycle where h_readyout = 1).
  - Byte enable = lane mask from size and address, ANDed with h_wstrb. Lane mask: word 1111, halfword 0011 or 1100 (by addr[1]), byte one-hot on addr[1:0].
  - Only enabled bytes change. An erroring transfer writes nothing.
- Read data:
  - h_rdata = selected register in the final OKAY data cycle. For a read-only register, h_rdata = hw_in slice, sampled combinationally in that cycle.
  - h_rdata = 0 during wait, error and idle cycles.
  - Full 32-bit word is returned regardless of h_size.
- Write followed by read of the same register returns the new value with no stall.
- reg_out reflects writes in the cycle after commit. Read-only slices of reg_out mirror hw_in.

Test Plan:
- Reset value: reset, NumRegs = 64, read all 64 aligned word addresses -> all 32'h0, h_resp = 0, zero wait states.
- Back-to-back R/W with waits: ReadWaitStates = 2, WriteWaitStates = 1; write 32'hDEAD_BEEF to BaseAddr+8 then read it back -> write data phase is 2 cycles, read data phase is 3 cycles (h_readyout low 2 cycles), h_rdata = 32'hDEAD_BEEF.
- Strobes and size: write 32'hFFFF_FFFF to reg 0; then write byte 8'hA5 at BaseAddr+2 with h_wstrb = 4'hF; then a word write of 32'h1234_5678 with h_wstrb = 4'b0001 -> read reg 0 = 32'hFFA5_FF78.
- Errors: with h_sel forced, word read at BaseAddr+1, BaseAddr+4*NumRegs, and h_size = 011 -> each gives ERR1 (h_readyout = 0, h_resp = 1) then ERR2 (h_readyout = 1, h_resp = 1); no register changes.
- Read-only: ReadOnlyMask bit 3 = 1, hw_in[3] = 32'hCAFE_0003; write 32'h0 to reg 3 -> two-cycle ERROR; read reg 3 -> 32'hCAFE_0003 OKAY.
- Reset mid-transfer: assert h_reset_n = 0 during WAIT of a write of 32'h5555_5555 -> h_readyout = 1 immediately, h_resp = 0; register reads 0 after reset.
